// File: rtl/apb_mc_pkg.sv
// Shared types and helpers for the multi-completer APB4 requester.
package apb_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Error flag reported for an address that hits no completer.
    localparam logic RSP_ERR_DECODE = 1'b1;

    // Width of the completer index field; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_mc_decoder.sv
// Completer address decoder: index field, hit flag and one-hot PSEL vector.
// A hit needs an index below NUM_SLV and every address bit above the field clear.
module apb_mc_decoder
    import apb_mc_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SLV_LSB = 12
) (
    input  logic [ADDR_W-1:0]         addr,
    output logic [sel_w(NUM_SLV)-1:0] idx,
    output logic                      hit,
    output logic [NUM_SLV-1:0]        sel
);

    localparam int SW = sel_w(NUM_SLV);

    logic [ADDR_W-1:0] field;

    // Shift the index field down, then check range and the bits above it.
    always_comb begin
        field = addr >> SLV_LSB;
        idx   = field[SW-1:0];
        hit   = (32'(idx) < NUM_SLV) && ((field >> SW) == '0);
        sel   = '0;
        if (hit) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_mc.sv
// Multi-completer APB4 requester: one CPU request at a time, SETUP/ACCESS
// sequence on the decoded completer, one-cycle response pulse.
// Optional ACCESS-phase timeout: define APB_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | req_ready=1, waiting for a request
//  SETUP  | PSELx asserted, PENABLE=0
//  ACCESS | PENABLE=1, waiting on PREADY of the selected completer
//  RESP   | rsp_valid pulse with captured data/error
module apb_master_mc
    import apb_mc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int SLV_LSB     = 12,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/8-1:0]       req_strb,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        PSELx,
    output logic                      PENABLE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    output logic [2:0]                PPROT,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int SW     = sel_w(NUM_SLV);
    localparam int STRB_W = DATA_W / 8;

    state_t              state, state_nxt;
    logic [SW-1:0]       dec_idx, idx_q;
    logic                dec_hit;
    logic [NUM_SLV-1:0]  dec_sel, sel_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q, prdata_sel;
    logic [STRB_W-1:0]   strb_q;
    logic [2:0]          prot_q;
    logic                write_q, err_q;
    logic                accept, pready_sel, pslverr_sel, timeout_hit;

    apb_mc_decoder #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV),
        .SLV_LSB (SLV_LSB)
    ) u_decoder (
        .addr (req_addr),
        .idx  (dec_idx),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    assign accept      = req_valid && (state == ST_IDLE);
    assign pready_sel  = PREADY[idx_q];
    assign pslverr_sel = PSLVERR[idx_q];
    assign prdata_sel  = PRDATA[32'(idx_q)*DATA_W +: DATA_W];

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt;

    // ACCESS wait timer: loaded in SETUP, terminal count on the last allowed cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            to_cnt <= '0;
        end else if (state == ST_SETUP) begin
            to_cnt <= TO_W'(TIMEOUT_CYC - 1);
        end else if ((state == ST_ACCESS) && (to_cnt != '0)) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    assign timeout_hit = (state == ST_ACCESS) && (to_cnt == '0);
`else
    logic [31:0] timeout_unused;

    assign timeout_unused = 32'(TIMEOUT_CYC);
    assign timeout_hit    = 1'b0;
`endif

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a decode miss skips the bus and responds at once.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_valid) state_nxt = dec_hit ? ST_SETUP : ST_RESP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (pready_sel || timeout_hit) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs; PSEL/PENABLE only live in SETUP and ACCESS.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        PSELx     = '0;
        PENABLE   = 1'b0;
        case (state)
            ST_IDLE:   req_ready = 1'b1;
            ST_SETUP:  PSELx = sel_q;
            ST_ACCESS: begin
                PSELx   = sel_q;
                PENABLE = 1'b1;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    // Request latch and response capture; bus fields hold between transfers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            paddr_q <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            write_q <= 1'b0;
            sel_q   <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= '0;
            err_q   <= dec_hit ? 1'b0 : RSP_ERR_DECODE;
            if (dec_hit) begin
                paddr_q <= req_addr;
                write_q <= req_write;
                wdata_q <= req_write ? req_wdata : '0;
                strb_q  <= req_write ? req_strb : '0;
                prot_q  <= req_prot;
                sel_q   <= dec_sel;
                idx_q   <= dec_idx;
            end
        end else if (state == ST_ACCESS) begin
            if (pready_sel) begin
                rdata_q <= write_q ? '0 : prdata_sel;
                err_q   <= pslverr_sel;
            end else if (timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign PADDR  = paddr_q;
    assign PWRITE = write_q;
    assign PWDATA = wdata_q;
    assign PSTRB  = strb_q;
    assign PPROT  = prot_q;

endmodule

// File: tb/tb_apb_master_mc.sv
`timescale 1ns/1ps
module tb_apb_master_mc;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int NUM_SLV     = 4;
    localparam int SLV_LSB     = 12;
    localparam int TIMEOUT_CYC = 8;

    logic                      PCLK = 1'b0;
    logic                      PRESET = 1'b1;
    logic                      req_valid = 1'b0;
    logic                      req_ready;
    logic                      req_write = 1'b0;
    logic [ADDR_W-1:0]         req_addr = '0;
    logic [DATA_W-1:0]         req_wdata = '0;
    logic [DATA_W/8-1:0]       req_strb = '0;
    logic [2:0]                req_prot = '0;
    logic                      rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [NUM_SLV-1:0]        PSELx;
    logic                      PENABLE;
    logic [ADDR_W-1:0]         PADDR;
    logic                      PWRITE;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W/8-1:0]       PSTRB;
    logic [2:0]                PPROT;
    logic [NUM_SLV-1:0]        PREADY = '0;
    logic [NUM_SLV*DATA_W-1:0] PRDATA = '0;
    logic [NUM_SLV-1:0]        PSLVERR = '0;

    apb_master_mc #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_SLV     (NUM_SLV),
        .SLV_LSB     (SLV_LSB),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;   // accept-to-response cycles; 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every response pulse pops one expectation.
    always @(negedge PCLK) begin
        exp_t e;
        if (rsp_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding, required 0", rsp_valid);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                if (e.lat > 0) chk("rsp_latency", 64'(cyc - acc_cyc + 1), 64'(e.lat));
            end
        end
    end

    task automatic push(input logic [31:0] rdata, input logic err, input int lat);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.lat   = lat;
        exp_q.push_back(e);
    endtask

    // Present a request and return just after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        req_prot  = p;
        chk("req_ready_at_accept", 64'(req_ready), 64'd1);
        @(posedge PCLK);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int limit);
        int n;
        n = 0;
        @(negedge PCLK);
        while (rsp_valid !== 1'b1 && n < limit) begin
            n++;
            @(negedge PCLK);
        end
        if (rsp_valid !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no rsp_valid within %0d cycles, required a response", name, limit);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    initial begin : stim
        int n;

        // Reset
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_outputs", {rsp_valid, rsp_err, PSELx, PENABLE, PWRITE, PSTRB, PPROT,
                              |PADDR, |PWDATA, |rsp_rdata}, 64'd0);
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);

        // 1: write to completer 1, ready at once; unselected lines noisy
        PREADY  = 4'b0011;
        PSLVERR = 4'b1101;
        push(32'h0, 1'b0, 3);
        issue(1'b1, 32'h0000_1004, 32'hA5A5_1234, 4'hF, 3'b101);
        @(negedge PCLK);
        chk("t1_setup_psel", 64'(PSELx), 64'b0010);
        chk("t1_setup_penable", 64'(PENABLE), 64'd0);
        chk("t1_paddr", 64'(PADDR), 64'h0000_1004);
        chk("t1_pwdata", 64'(PWDATA), 64'hA5A5_1234);
        chk("t1_pstrb_pwrite_pprot", {PSTRB, PWRITE, PPROT}, {4'hF, 1'b1, 3'b101});
        @(negedge PCLK);
        chk("t1_access", {PSELx, PENABLE}, {4'b0010, 1'b1});
        @(negedge PCLK);
        chk("t1_resp_bus_idle", {PSELx, PENABLE}, 64'd0);
        @(negedge PCLK);
        chk("t1_single_pulse_idle", {rsp_valid, req_ready}, 2'b01);
        chk("t1_paddr_hold", 64'(PADDR), 64'h0000_1004);

        // 2: read from completer 3 with three wait states
        PREADY  = 4'b0111;
        PSLVERR = 4'b0000;
        PRDATA  = {32'hDEAD_BEEF, 32'h7777_0000, 32'h5555_5555, 32'h1234_5678};
        push(32'hDEAD_BEEF, 1'b0, 6);
        issue(1'b0, 32'h0000_3008, 32'hFFFF_FFFF, 4'hF, 3'b000);
        @(negedge PCLK);
        chk("t2_setup_psel", 64'(PSELx), 64'b1000);
        chk("t2_read_strb_wdata", {PSTRB, PWRITE, |PWDATA}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("t2_wait_state", {PENABLE, rsp_valid}, 2'b10);
        end
        @(posedge PCLK);
        #1 PREADY[3] = 1'b1;
        @(negedge PCLK);
        chk("t2_ready_cycle", 64'(PENABLE), 64'd1);
        @(negedge PCLK);
        chk("t2_resp_bus_idle", {PSELx, PENABLE}, 64'd0);
        @(posedge PCLK);
        #1 PREADY = '0;
        @(negedge PCLK);

        // 3: decode errors (bit above field; then top bit with in-range index)
        PREADY = 4'b1111;
        push(32'h0, 1'b1, 1);
        issue(1'b0, 32'h0001_0000, 32'h0, 4'h0, 3'b000);
        @(negedge PCLK);
        chk("t3_no_psel", {PSELx, PENABLE}, 64'd0);
        @(negedge PCLK);
        chk("t3_after", {PSELx, rsp_valid}, 64'd0);
        push(32'h0, 1'b1, 1);
        issue(1'b1, 32'h8000_3000, 32'h1, 4'hF, 3'b000);
        @(negedge PCLK);
        chk("t3b_no_psel", {PSELx, PENABLE}, 64'd0);
        @(negedge PCLK);

        // 4: PSLVERR on a write to completer 2; PRDATA ignored
        PREADY  = 4'b0100;
        PSLVERR = 4'b0100;
        PRDATA  = {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
        push(32'h0, 1'b1, 3);
        issue(1'b1, 32'h0000_2000, 32'h1234_5678, 4'h3, 3'b010);
        repeat (3) @(negedge PCLK);
        @(negedge PCLK);
        chk("t4_single_pulse", 64'(rsp_valid), 64'd0);
        PSLVERR = '0;

        // 5: reset during ACCESS, then a clean transfer
        PREADY = '0;
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b001);
        repeat (2) @(negedge PCLK);
        chk("t5_in_access", 64'(PENABLE), 64'd1);
        @(posedge PCLK);
        #1 PRESET = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("t5_reset_req_ready", 64'(req_ready), 64'd1);
        chk("t5_reset_outputs", {rsp_valid, rsp_err, PSELx, PENABLE, PWRITE, PSTRB, PPROT,
                                 |PADDR, |PWDATA, |rsp_rdata}, 64'd0);
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        repeat (3) @(negedge PCLK);
        PREADY = 4'b0010;
        PRDATA = {32'h0, 32'h0, 32'h1111_2222, 32'h0};
        push(32'h1111_2222, 1'b0, 3);
        issue(1'b0, 32'h0000_1010, 32'h0, 4'h0, 3'b000);
        wait_rsp("t5_after_reset", 10);
        @(negedge PCLK);

        // 6: a completer that never answers
        PREADY  = '0;
`ifdef APB_TIMEOUT_EN
        PSLVERR = '0;
        push(32'h0, 1'b1, 10);
        issue(1'b1, 32'h0000_0000, 32'h9, 4'hF, 3'b000);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (rsp_valid === 1'b1) break;
            if (PENABLE === 1'b1) n++;
        end
        chk("t6_access_cycles", 64'(n), 64'd8);
        @(negedge PCLK);
        // PREADY on the last allowed ACCESS cycle still completes normally
        PRDATA = {32'h0, 32'h0, 32'h0BAD_C0DE, 32'h0};
        push(32'h0BAD_C0DE, 1'b0, 10);
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000);
        repeat (8) @(posedge PCLK);
        #1 PREADY[1] = 1'b1;
        wait_rsp("t6_limit_ready", 5);
        @(posedge PCLK);
        #1 PREADY = '0;
`else
        push(32'h0, 1'b0, 0);
        issue(1'b1, 32'h0000_0000, 32'h9, 4'hF, 3'b000);
        @(negedge PCLK);
        n = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge PCLK);
            if (PENABLE === 1'b1 && rsp_valid === 1'b0) n++;
        end
        chk("t6_no_timeout_penable", 64'(n), 64'd120);
        @(posedge PCLK);
        #1 PREADY[0] = 1'b1;
        wait_rsp("t6_late_ready", 5);
        @(posedge PCLK);
        #1 PREADY = '0;
`endif
        repeat (3) @(negedge PCLK);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
